// File: rtl/writeback_queue_pkg.sv
// Shared definitions for the writeback queue: default widths, the queue
// entry layout {idx, val} and the hard-wired zero register index.
package writeback_queue_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int IDX_W_DEF  = 5;
    localparam int DEPTH_DEF  = 2;

    // Register r0 is never written; results targeting it are dropped.
    localparam int REG_ZERO   = 0;

    // Queue entry layout at the default widths: index in the upper bits,
    // value in the lower bits. Parameterised users build the same layout
    // as a flat {idx, val} vector of entry_w() bits.
    typedef struct packed {
        logic [IDX_W_DEF-1:0]  idx;
        logic [DATA_W_DEF-1:0] val;
    } wb_entry_t;

    function automatic int entry_w(input int data_w, input int idx_w);
        return data_w + idx_w;
    endfunction

endpackage

// File: rtl/writeback_queue_wb_fifo.sv
// wb_fifo: small in-order queue with wrapping head/tail pointers and an
// occupancy count one bit wider than the pointers. All slots are exposed
// so the parent can search pending entries for forwarding.
module wb_fifo
    import writeback_queue_pkg::*;
#(
    parameter int W     = entry_w(DATA_W_DEF, IDX_W_DEF),
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push_i,
    input  logic                          pop_i,
    input  logic [W-1:0]                  din_i,
    output logic [W-1:0]                  head_o,
    output logic [DEPTH-1:0][W-1:0]       slots_o,
    output logic [$clog2(DEPTH)-1:0]      head_ptr_o,
    output logic [$clog2(DEPTH):0]        count_o,
    output logic                          full_o,
    output logic                          empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DEPTH-1:0][W-1:0] mem_q;
    logic [PTR_W-1:0]        head_q;
    logic [PTR_W-1:0]        tail_q;
    logic [CNT_W-1:0]        count_q;
    logic                    push_en;
    logic                    pop_en;

    assign empty_o    = (count_q == '0);
    assign full_o     = (count_q == CNT_W'(DEPTH));

    // A pop on an empty queue is ignored; a push when full is only taken
    // if a pop frees the head slot in the same cycle.
    assign pop_en     = pop_i & ~empty_o;
    assign push_en    = push_i & (~full_o | pop_en);

    assign head_o     = mem_q[head_q];
    assign slots_o    = mem_q;
    assign head_ptr_o = head_q;
    assign count_o    = count_q;

    // Storage, pointer and count update; reset discards all entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_en) begin
                mem_q[tail_q] <= din_i;
                tail_q        <= tail_q + PTR_W'(1);
            end
            if (pop_en) begin
                head_q <= head_q + PTR_W'(1);
            end
            case ({push_en, pop_en})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/writeback_queue.sv
// writeback_queue: writeback stage after memory. Selects load or ALU
// result, queues register-file writes in order, drains them through a
// shared write port and forwards pending values to execute.
// Optional feature macro: WB_RETIRE_CNT_EN adds the retire_cnt port and a
// 32-bit counter of accepted instructions.
module writeback_queue
    import writeback_queue_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int IDX_W  = IDX_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              is_ld_op_passthrough,
    input  logic              is_wb_op_passthrough,
    input  logic [IDX_W-1:0]  rd_idx_passthrough,
    input  logic [DATA_W-1:0] rd_val_passthrough,
    input  logic [DATA_W-1:0] dmem_val_passthrough,
    output logic              rf_write_en,
    output logic [IDX_W-1:0]  rf_write_idx,
    output logic [DATA_W-1:0] rf_write_val,
    input  logic              rf_grant,
    input  logic [IDX_W-1:0]  fwd_idx,
    output logic              fwd_hit,
    output logic [DATA_W-1:0] fwd_val
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [31:0]       retire_cnt
`endif
);

    localparam int ENTRY_W = entry_w(DATA_W, IDX_W);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;

    logic [DATA_W-1:0]            result_val;
    logic                         accept;
    logic                         push;
    logic                         pop;
    logic [ENTRY_W-1:0]           head_entry;
    logic [DEPTH-1:0][ENTRY_W-1:0] slots;
    logic [PTR_W-1:0]             head_ptr;
    logic [CNT_W-1:0]             count;
    logic                         full;
    logic                         empty;
    logic [IDX_W-1:0]             slot_idx [DEPTH];
    logic [DATA_W-1:0]            slot_val [DEPTH];
    logic [PTR_W-1:0]             slot_sel;

    assign result_val = is_ld_op_passthrough ? dmem_val_passthrough : rd_val_passthrough;

    // The head is only written out when present, and a grant pops it.
    assign rf_write_en = ~empty;
    assign pop         = rf_write_en & rf_grant;

    // A full queue still accepts when the head leaves in the same cycle.
    assign in_ready    = ~full | pop;
    assign accept      = in_valid & in_ready;

    // Stores and writes to r0 retire without occupying a queue slot.
    assign push        = accept & is_wb_op_passthrough &
                         (rd_idx_passthrough != IDX_W'(REG_ZERO));

    wb_fifo #(
        .W     (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (reset),
        .push_i     (push),
        .pop_i      (pop),
        .din_i      ({rd_idx_passthrough, result_val}),
        .head_o     (head_entry),
        .slots_o    (slots),
        .head_ptr_o (head_ptr),
        .count_o    (count),
        .full_o     (full),
        .empty_o    (empty)
    );

    // Storage slots are reset-cleared, but gate anyway so an empty queue
    // always presents zeros regardless of stale slot contents.
    assign rf_write_idx = empty ? '0 : head_entry[ENTRY_W-1 -: IDX_W];
    assign rf_write_val = empty ? '0 : head_entry[DATA_W-1:0];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            assign slot_idx[gi] = slots[gi][ENTRY_W-1 -: IDX_W];
            assign slot_val[gi] = slots[gi][DATA_W-1:0];
        end
    endgenerate

    // Forward search walks entries oldest to newest so the newest match
    // overwrites older ones; the head still hits in the cycle it is popped.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_val  = '0;
        slot_sel = '0;
        for (int k = 0; k < DEPTH; k++) begin
            slot_sel = head_ptr + PTR_W'(k);
            if ((CNT_W'(k) < count) &&
                (fwd_idx != IDX_W'(REG_ZERO)) &&
                (slot_idx[slot_sel] == fwd_idx)) begin
                fwd_hit = 1'b1;
                fwd_val = slot_val[slot_sel];
            end
        end
    end

`ifdef WB_RETIRE_CNT_EN
    logic [31:0] retire_cnt_q;

    // Count every accepted instruction, writing or not; wraps naturally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retire_cnt_q <= '0;
        end else if (accept) begin
            retire_cnt_q <= retire_cnt_q + 32'd1;
        end
    end

    assign retire_cnt = retire_cnt_q;
`endif

endmodule

// File: tb/tb_writeback_queue.sv
// Testbench for writeback_queue: directed scenarios followed by random
// traffic, checked against a queue-based reference model.
module tb_writeback_queue;

    localparam int DATA_W = 32;
    localparam int IDX_W  = 5;
    localparam int DEPTH  = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic              is_ld_op_passthrough;
    logic              is_wb_op_passthrough;
    logic [IDX_W-1:0]  rd_idx_passthrough;
    logic [DATA_W-1:0] rd_val_passthrough;
    logic [DATA_W-1:0] dmem_val_passthrough;
    logic              rf_write_en;
    logic [IDX_W-1:0]  rf_write_idx;
    logic [DATA_W-1:0] rf_write_val;
    logic              rf_grant;
    logic [IDX_W-1:0]  fwd_idx;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_val;
`ifdef WB_RETIRE_CNT_EN
    logic [31:0]       retire_cnt;
`endif

    always #5 clk = ~clk;

    writeback_queue #(
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .in_valid             (in_valid),
        .in_ready             (in_ready),
        .is_ld_op_passthrough (is_ld_op_passthrough),
        .is_wb_op_passthrough (is_wb_op_passthrough),
        .rd_idx_passthrough   (rd_idx_passthrough),
        .rd_val_passthrough   (rd_val_passthrough),
        .dmem_val_passthrough (dmem_val_passthrough),
        .rf_write_en          (rf_write_en),
        .rf_write_idx         (rf_write_idx),
        .rf_write_val         (rf_write_val),
        .rf_grant             (rf_grant),
        .fwd_idx              (fwd_idx),
        .fwd_hit              (fwd_hit),
        .fwd_val              (fwd_val)
`ifdef WB_RETIRE_CNT_EN
        ,
        .retire_cnt           (retire_cnt)
`endif
    );

    typedef struct packed {
        logic [IDX_W-1:0]  idx;
        logic [DATA_W-1:0] val;
    } ent_t;

    typedef struct packed {
        logic              ld;
        logic              wb;
        logic [IDX_W-1:0]  idx;
        logic [DATA_W-1:0] rdv;
        logic [DATA_W-1:0] dmv;
    } txn_t;

    txn_t        stim_q[$];     // transactions waiting to be presented
    ent_t        model_q[$];    // expected pending register-file writes
    int          vectors    = 0;
    int          miscompares = 0;
    bit          accepted_last = 1'b0;
    logic [31:0] exp_retire = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor/scoreboard: checks presented outputs against the model at
    // mid-cycle, then applies this cycle's pop and accept to the model.
    always @(negedge clk) begin : monitor
        int                n;
        logic              exp_ready;
        logic              exp_hit;
        logic [DATA_W-1:0] exp_fval;
        logic              acc;
        if (!reset) begin
            model_q.delete();
            exp_retire    = '0;
            accepted_last = 1'b0;
            chk("rst_write_en", 64'(rf_write_en), 64'(0));
            chk("rst_write_idx", 64'(rf_write_idx), 64'(0));
            chk("rst_write_val", 64'(rf_write_val), 64'(0));
            chk("rst_fwd_hit", 64'(fwd_hit), 64'(0));
            chk("rst_fwd_val", 64'(fwd_val), 64'(0));
`ifdef WB_RETIRE_CNT_EN
            chk("rst_retire_cnt", 64'(retire_cnt), 64'(0));
`endif
        end else begin
            n         = model_q.size();
            exp_ready = (n < DEPTH) || ((n > 0) && rf_grant);
            exp_hit   = 1'b0;
            exp_fval  = '0;
            if (fwd_idx != 0) begin
                for (int i = n - 1; i >= 0; i--) begin
                    if (model_q[i].idx == fwd_idx) begin
                        exp_hit  = 1'b1;
                        exp_fval = model_q[i].val;
                        break;
                    end
                end
            end
            chk("in_ready", 64'(in_ready), 64'(exp_ready));
            chk("rf_write_en", 64'(rf_write_en), 64'(n > 0));
            chk("fwd_hit", 64'(fwd_hit), 64'(exp_hit));
            chk("fwd_val", 64'(fwd_val), 64'(exp_fval));
            if (n > 0) begin
                chk("rf_write_idx", 64'(rf_write_idx), 64'(model_q[0].idx));
                chk("rf_write_val", 64'(rf_write_val), 64'(model_q[0].val));
            end else begin
                chk("empty_write_idx", 64'(rf_write_idx), 64'(0));
                chk("empty_write_val", 64'(rf_write_val), 64'(0));
            end
`ifdef WB_RETIRE_CNT_EN
            chk("retire_cnt", 64'(retire_cnt), 64'(exp_retire));
`endif
            if ((n > 0) && rf_grant) begin
                void'(model_q.pop_front());
            end
            acc           = in_valid && exp_ready;
            accepted_last = acc;
            if (acc) begin
                exp_retire = exp_retire + 32'd1;
                if (is_wb_op_passthrough && (rd_idx_passthrough != 0)) begin
                    model_q.push_back({rd_idx_passthrough,
                        is_ld_op_passthrough ? dmem_val_passthrough : rd_val_passthrough});
                end
            end
        end
    end

    // One clock of stimulus: keep a held transaction stable, otherwise
    // present the next queued one; grant and lookup index change freely.
    task automatic cycle(input logic g, input logic [IDX_W-1:0] f);
        txn_t t;
        @(posedge clk);
        #1;
        if (!in_valid || accepted_last) begin
            if (stim_q.size() > 0) begin
                t                    = stim_q.pop_front();
                in_valid             = 1'b1;
                is_ld_op_passthrough = t.ld;
                is_wb_op_passthrough = t.wb;
                rd_idx_passthrough   = t.idx;
                rd_val_passthrough   = t.rdv;
                dmem_val_passthrough = t.dmv;
                $display("issue ld=%0d wb=%0d idx=%0d rd=0x%0h dmem=0x%0h",
                         t.ld, t.wb, t.idx, t.rdv, t.dmv);
            end else begin
                in_valid = 1'b0;
            end
        end
        rf_grant = g;
        fwd_idx  = f;
    endtask

    task automatic add(input logic ld, input logic wb, input int idx,
                       input logic [DATA_W-1:0] rdv, input logic [DATA_W-1:0] dmv);
        txn_t t;
        t.ld  = ld;
        t.wb  = wb;
        t.idx = IDX_W'(idx);
        t.rdv = rdv;
        t.dmv = dmv;
        stim_q.push_back(t);
    endtask

    initial begin
        int guard;
        reset                = 1'b0;
        in_valid             = 1'b0;
        is_ld_op_passthrough = 1'b0;
        is_wb_op_passthrough = 1'b0;
        rd_idx_passthrough   = '0;
        rd_val_passthrough   = '0;
        dmem_val_passthrough = '0;
        rf_grant             = 1'b0;
        fwd_idx              = '0;
        repeat (3) cycle(1'b0, '0);
        @(posedge clk); #1; reset = 1'b1;

        // ALU op, then drain with grant
        add(1'b0, 1'b1, 3, 32'h11, 32'h99);
        cycle(1'b0, '0);
        cycle(1'b1, 5'd3);
        repeat (2) cycle(1'b1, '0);

        // Load selects memory data
        add(1'b1, 1'b1, 4, 32'h4, 32'hA5A5);
        cycle(1'b0, 5'd4);
        repeat (3) cycle(1'b1, '0);

        // Back-pressure: three writes with no grant, then drain in order
        add(1'b0, 1'b1, 1, 32'h101, 32'h0);
        add(1'b0, 1'b1, 2, 32'h202, 32'h0);
        add(1'b0, 1'b1, 3, 32'h303, 32'h0);
        repeat (5) cycle(1'b0, 5'd2);
        repeat (6) cycle(1'b1, '0);

        // Full queue with push and grant in the same cycle
        add(1'b0, 1'b1, 6, 32'h6, 32'h0);
        add(1'b0, 1'b1, 7, 32'h7, 32'h0);
        add(1'b1, 1'b1, 8, 32'h0, 32'h8);
        repeat (3) cycle(1'b0, 5'd7);
        cycle(1'b1, 5'd8);
        repeat (4) cycle(1'b1, '0);

        // Newest matching entry forwards; index 0 never hits
        add(1'b0, 1'b1, 5, 32'h1, 32'h0);
        add(1'b0, 1'b1, 5, 32'h2, 32'h0);
        repeat (3) cycle(1'b0, 5'd5);
        cycle(1'b0, '0);
        cycle(1'b1, 5'd5);
        repeat (3) cycle(1'b1, '0);

        // Store and r0 write produce no register-file request
        add(1'b0, 1'b0, 9, 32'h9, 32'h0);
        add(1'b0, 1'b1, 0, 32'hDEAD, 32'h0);
        repeat (4) cycle(1'b1, '0);

        // Asynchronous reset mid-drain clears outputs immediately
        add(1'b0, 1'b1, 10, 32'hA0, 32'h0);
        add(1'b0, 1'b1, 11, 32'hB0, 32'h0);
        repeat (3) cycle(1'b0, 5'd10);
        cycle(1'b1, 5'd10);
        #2;
        reset    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("async_write_en", 64'(rf_write_en), 64'(0));
        chk("async_write_idx", 64'(rf_write_idx), 64'(0));
        chk("async_write_val", 64'(rf_write_val), 64'(0));
        chk("async_fwd_hit", 64'(fwd_hit), 64'(0));
        repeat (2) cycle(1'b0, '0);
        @(posedge clk); #1; reset = 1'b1;

        // Random traffic
        for (int c = 0; c < 600; c++) begin
            if (stim_q.size() < 2) begin
                add(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                    int'($urandom_range(0, 7)), $urandom, $urandom);
            end
            cycle(1'($urandom_range(0, 1)), IDX_W'($urandom_range(0, 7)));
        end

        // Final drain, bounded
        guard = 0;
        while ((stim_q.size() > 0 || in_valid || model_q.size() > 0) && guard < 100) begin
            cycle(1'b1, '0);
            guard++;
        end
        if (guard >= 100) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: got %0d pending expected 0", model_q.size());
        end
        cycle(1'b0, '0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
